if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter: RESET_PC, default 64'h0000_0000_0000_0000, first fetch address after reset.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 imem_req_valid  out  1  fetch request present.
REQ-005 imem_req_addr  out  64  fetch byte address, bits[1:0] always 0.
REQ-006 imem_req_ready  in  1  memory accepts request this cycle.
REQ-007 imem_rsp_valid  in  1  instruction word returned this cycle.
REQ-008 imem_rsp_data  in  32  returned instruction word.
REQ-009 redirect_valid  in  1  taken branch/jump from EX, flush and refetch.
REQ-010 redirect_pc  in  64  new fetch address.
REQ-011 id_stall  in  1  decode stage cannot accept, hold ID outputs.
REQ-012 id_valid  out  1  ID outputs carry a real instruction.
REQ-013 id_instr  out  32  instruction to decode/immediate generator.
REQ-014 id_pc  out  64  address of id_instr.

Function
REQ-015 Block SHALL be a 4-state FSM: IDLE, FETCH, WAIT, HOLD, with at most one imem request outstanding.
REQ-016 IDLE: imem_req_valid=0; unconditional transition to FETCH next cycle.
REQ-017 FETCH: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready=1 go WAIT, else stay.
REQ-018 WAIT: on imem_rsp_valid=1 with no drop pending: if id_stall=0 or id_valid=0, load ID registers (instr, pc, valid=1), pc<=pc+4, go FETCH; else capture into 1-entry hold buffer, pc<=pc+4, go HOLD.
REQ-019 HOLD: imem_req_valid=0; when id_stall=0, buffer moves to ID registers, go FETCH.
REQ-020 ID registers SHALL not change while id_stall=1, except on redirect.
REQ-021 When ID registers are consumed (id_stall=0) and no new word loads that cycle, id_valid SHALL clear next cycle.
REQ-022 id_valid=0 SHALL present id_instr=32'h0000_0013 (NOP); id_pc=pc of last valid or RESET_PC.
REQ-023 Redirect has highest priority: next cycle id_valid=0, hold buffer cleared, pc<=redirect_pc with bits[1:0] forced to 0; id_stall ignored.
REQ-024 Redirect in WAIT without same-cycle response, or in FETCH with same-cycle imem_req_ready=1: set drop flag, go/stay WAIT; next response discarded, then go FETCH at redirect address.
REQ-025 Redirect in WAIT coinciding with imem_rsp_valid: response discarded, no drop flag, go FETCH.
REQ-026 Redirect in FETCH without req_ready, or in HOLD/IDLE: go FETCH at redirect address.
REQ-027 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-028 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-029 Peak throughput: one instruction per 2 cycles with zero-wait memory.

Reset
REQ-030 rst_n low SHALL immediately force: state=IDLE, pc=RESET_PC, drop=0, buffer empty, imem_req_valid=0, id_valid=0, id_instr=NOP, id_pc=RESET_PC.
REQ-031 Reset mid-WAIT: outstanding response abandoned; first request after release is RESET_PC.

Structure
REQ-032 Shared package pipe_pkg holds: NOP encoding 32'h0000_0013, state enum, XLEN=64, ILEN=32.
REQ-033 Hold buffer SHALL be sub-module if_hold_buf (1-entry instr+pc, load/drain/clear, full flag).

Verification
REQ-034 Reset release, RESET_PC=0, ready=1, 1-cycle response 32'h0010_0083 -> req addr 0 in cycle 2, id_valid=1, id_instr=32'h0010_0083, id_pc=0 two cycles later; next req addr 4.
REQ-035 id_stall=1 while id_valid=1, response 32'h0020_2023 arrives -> state HOLD, no new request, ID unchanged; stall drops -> ID shows 32'h0020_2023, request addr+4 follows.
REQ-036 Redirect to 64'h100 in WAIT, response next cycle -> response discarded, id_valid=0 (NOP), next request addr 64'h100.
REQ-037 Redirect to 64'h203 during HOLD with id_stall=1 -> buffer cleared, id_valid=0, next request addr 64'h200.
REQ-038 pc=64'hFFFF_FFFF_FFFF_FFFC fetched -> next request addr 0.
REQ-039 rst_n asserted in WAIT -> outputs at reset values immediately; late response ignored; first request RESET_PC.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the
// fetch/decode front end.
package pipe_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_HOLD
   } if_state_e;

   function automatic logic [XLEN-1:0] pc_align(
      input logic [XLEN-1:0] a
   );
      return a & ~64'h3;
   endfunction

   function automatic logic [XLEN-1:0] pc_inc(
      input logic [XLEN-1:0] a
   );
      return a + 64'd4;
   endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer for a fetched word that
// arrives while decode is stalled.
module if_hold_buf
   import pipe_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            drain,
   input  logic            clear,
   input  logic [ILEN-1:0] ld_instr,
   input  logic [XLEN-1:0] ld_pc,
   output logic            full,
   output logic [ILEN-1:0] buf_instr,
   output logic [XLEN-1:0] buf_pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full      <= 1'b0;
         buf_instr <= NOP;
         buf_pc    <= '0;
      end else if (clear || drain) begin
         full      <= 1'b0;
      end else if (load) begin
         full      <= 1'b1;
         buf_instr <= ld_instr;
         buf_pc    <= ld_pc;
      end
   end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch with IF/ID register: one
// outstanding imem request, redirect flush.
module if_id_stage
   import pipe_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   output logic [63:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        id_stall,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [63:0] id_pc
);

   if_state_e       state, state_d;
   logic [XLEN-1:0] pc, pc_d;
   logic            drop, drop_d;
   logic            vld_d;
   logic [ILEN-1:0] instr_d;
   logic [XLEN-1:0] idpc_d;
   logic            buf_load, buf_drain, buf_clear;
   logic            buf_full;
   logic [ILEN-1:0] buf_instr;
   logic [XLEN-1:0] buf_pc;
   logic            take;

   if_hold_buf u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (buf_load),
      .drain     (buf_drain),
      .clear     (buf_clear),
      .ld_instr  (imem_rsp_data),
      .ld_pc     (pc),
      .full      (buf_full),
      .buf_instr (buf_instr),
      .buf_pc    (buf_pc)
   );

   assign imem_req_valid = (state == S_FETCH);
   assign imem_req_addr  = pc;
   assign take           = !id_stall || !id_valid;

   always_comb begin
      state_d   = state;
      pc_d      = pc;
      drop_d    = drop;
      vld_d     = id_valid;
      instr_d   = id_instr;
      idpc_d    = id_pc;
      buf_load  = 1'b0;
      buf_drain = 1'b0;
      buf_clear = 1'b0;

      // a consumed ID slot empties unless refilled below
      if (!id_stall) begin
         vld_d   = 1'b0;
         instr_d = NOP;
      end

      if (redirect_valid) begin
         vld_d     = 1'b0;
         instr_d   = NOP;
         buf_clear = 1'b1;
         pc_d      = pc_align(redirect_pc);
         drop_d    = 1'b0;
         state_d   = S_FETCH;
         unique case (state)
            S_FETCH: begin
               if (imem_req_ready) begin
                  drop_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (!imem_rsp_valid) begin
                  drop_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end
            default: ;
         endcase
      end else begin
         unique case (state)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
               if (imem_req_ready)
                  state_d = S_WAIT;
            end
            S_WAIT: begin
               unique case (1'b1)
                  imem_rsp_valid && drop: begin
                     drop_d  = 1'b0;
                     state_d = S_FETCH;
                  end
                  imem_rsp_valid && !drop && take: begin
                     vld_d   = 1'b1;
                     instr_d = imem_rsp_data;
                     idpc_d  = pc;
                     pc_d    = pc_inc(pc);
                     state_d = S_FETCH;
                  end
                  imem_rsp_valid && !drop && !take: begin
                     buf_load = 1'b1;
                     pc_d     = pc_inc(pc);
                     state_d  = S_HOLD;
                  end
                  default: ;
               endcase
            end
            S_HOLD: begin
               if (!id_stall && buf_full) begin
                  vld_d     = 1'b1;
                  instr_d   = buf_instr;
                  idpc_d    = buf_pc;
                  buf_drain = 1'b1;
                  state_d   = S_FETCH;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= pc_align(RESET_PC);
         drop     <= 1'b0;
         id_valid <= 1'b0;
         id_instr <= NOP;
         id_pc    <= RESET_PC;
      end else begin
         state    <= state_d;
         pc       <= pc_d;
         drop     <= drop_d;
         id_valid <= vld_d;
         id_instr <= instr_d;
         id_pc    <= idpc_d;
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus
// random traffic against a transaction-level model.
module tb_if_id_stage;

   localparam logic [31:0] NOPW = 32'h0000_0013;

   logic        clk, rst_n;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        id_stall;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [63:0] id_pc;

   if_id_stage #(.RESET_PC(64'h0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;
   bit cmp_en = 1'b0;
   int delivered = 0;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h @%0t",
                  name, act, exp, $time);
      end
   endtask

   // model: outstanding-request flag, pending drop,
   // a queue for words parked while decode stalls
   typedef struct {
      logic [31:0] i;
      logic [63:0] p;
   } ent_t;

   bit          m_first, m_out, m_drop, m_vld;
   logic [31:0] m_instr;
   logic [63:0] m_pc, m_idpc;
   ent_t        m_hold[$];

   function automatic bit m_req();
      return !m_first && !m_out && (m_hold.size() == 0);
   endfunction

   task automatic model_reset();
      m_first = 1'b1;
      m_out   = 1'b0;
      m_drop  = 1'b0;
      m_vld   = 1'b0;
      m_instr = NOPW;
      m_pc    = 64'h0;
      m_idpc  = 64'h0;
      m_hold.delete();
   endtask

   task automatic model_step();
      bit   issued;
      bit   take;
      ent_t e;
      issued = m_req() && imem_req_ready;
      take   = !id_stall || !m_vld;
      if (redirect_valid) begin
         m_vld   = 1'b0;
         m_instr = NOPW;
         m_hold.delete();
         m_pc    = redirect_pc & ~64'h3;
         m_first = 1'b0;
         if (m_out) begin
            if (imem_rsp_valid) begin
               m_out  = 1'b0;
               m_drop = 1'b0;
            end else begin
               m_drop = 1'b1;
            end
         end else if (issued) begin
            m_out  = 1'b1;
            m_drop = 1'b1;
         end
      end else begin
         if (!id_stall) begin
            m_vld   = 1'b0;
            m_instr = NOPW;
         end
         if (m_first) begin
            m_first = 1'b0;
         end else if (issued) begin
            m_out = 1'b1;
         end else if (m_out && imem_rsp_valid) begin
            m_out = 1'b0;
            if (m_drop) begin
               m_drop = 1'b0;
            end else begin
               if (take) begin
                  m_vld   = 1'b1;
                  m_instr = imem_rsp_data;
                  m_idpc  = m_pc;
               end else begin
                  e.i = imem_rsp_data;
                  e.p = m_pc;
                  m_hold.push_back(e);
               end
               m_pc = m_pc + 64'd4;
            end
         end else if (m_hold.size() > 0 && !id_stall) begin
            e       = m_hold.pop_front();
            m_vld   = 1'b1;
            m_instr = e.i;
            m_idpc  = e.p;
         end
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         chk("req_valid", {63'b0, imem_req_valid},
             {63'b0, m_req()});
         if (m_req())
            chk("req_addr", imem_req_addr, m_pc);
         chk("id_valid", {63'b0, id_valid}, {63'b0, m_vld});
         chk("id_instr", {32'b0, id_instr}, {32'b0, m_instr});
         chk("id_pc", id_pc, m_idpc);
      end
   end

   task automatic drv(input bit rdy, input bit rv,
                      input logic [31:0] d, input bit st,
                      input bit rd, input logic [63:0] rp);
      imem_req_ready = rdy;
      imem_rsp_valid = rv;
      imem_rsp_data  = d;
      id_stall       = st;
      redirect_valid = rd;
      redirect_pc    = rp;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      drv(0, 0, 32'h0, 0, 0, 64'h0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_req_valid", {63'b0, imem_req_valid}, 64'h0);
      chk("rst_id_valid", {63'b0, id_valid}, 64'h0);
      chk("rst_id_instr", {32'b0, id_instr}, {32'b0, NOPW});
      chk("rst_id_pc", id_pc, 64'h0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // first fetch and delivery
      drv(1, 0, 32'h0, 0, 0, 64'h0);
      tick();
      chk("c2_req_valid", {63'b0, imem_req_valid}, 64'h1);
      chk("c2_req_addr", imem_req_addr, 64'h0);
      tick();
      chk("wait_no_req", {63'b0, imem_req_valid}, 64'h0);
      drv(1, 1, 32'h0010_0083, 0, 0, 64'h0);
      tick();
      chk("a_valid", {63'b0, id_valid}, 64'h1);
      chk("a_instr", {32'b0, id_instr}, 64'h0010_0083);
      chk("a_pc", id_pc, 64'h0);
      chk("a_next_addr", imem_req_addr, 64'h4);

      // stall into hold buffer
      drv(1, 0, 32'h0, 1, 0, 64'h0);
      tick();
      drv(0, 1, 32'h0020_2023, 1, 0, 64'h0);
      tick();
      chk("hold_no_req", {63'b0, imem_req_valid}, 64'h0);
      chk("hold_instr", {32'b0, id_instr}, 64'h0010_0083);
      chk("hold_pc", id_pc, 64'h0);
      drv(0, 0, 32'h0, 1, 0, 64'h0);
      tick();
      chk("hold2_no_req", {63'b0, imem_req_valid}, 64'h0);
      drv(0, 0, 32'h0, 0, 0, 64'h0);
      tick();
      chk("drain_instr", {32'b0, id_instr}, 64'h0020_2023);
      chk("drain_pc", id_pc, 64'h4);
      chk("drain_addr", imem_req_addr, 64'h8);

      // redirect in WAIT, response next cycle
      drv(1, 0, 32'h0, 0, 0, 64'h0);
      tick();
      drv(0, 0, 32'h0, 0, 1, 64'h100);
      tick();
      chk("rd_wait_valid", {63'b0, id_valid}, 64'h0);
      chk("rd_wait_noreq", {63'b0, imem_req_valid}, 64'h0);
      drv(0, 1, 32'hDEAD_BEEF, 0, 0, 64'h0);
      tick();
      chk("drop_valid", {63'b0, id_valid}, 64'h0);
      chk("drop_instr", {32'b0, id_instr}, {32'b0, NOPW});
      chk("drop_addr", imem_req_addr, 64'h100);

      // redirect during HOLD with stall
      drv(1, 0, 32'h0, 0, 0, 64'h0);
      tick();
      drv(0, 1, 32'h0030_0093, 0, 0, 64'h0);
      tick();
      drv(1, 0, 32'h0, 1, 0, 64'h0);
      tick();
      drv(0, 1, 32'h0040_0113, 1, 0, 64'h0);
      tick();
      chk("h2_no_req", {63'b0, imem_req_valid}, 64'h0);
      drv(0, 0, 32'h0, 1, 1, 64'h203);
      tick();
      chk("rdh_valid", {63'b0, id_valid}, 64'h0);
      chk("rdh_instr", {32'b0, id_instr}, {32'b0, NOPW});
      chk("rdh_addr", imem_req_addr, 64'h200);
      drv(1, 0, 32'h0, 0, 0, 64'h0);
      tick();
      drv(0, 1, 32'h0050_0193, 0, 0, 64'h0);
      tick();
      chk("rdh_c_instr", {32'b0, id_instr}, 64'h0050_0193);
      chk("rdh_c_pc", id_pc, 64'h200);

      // pc wrap at top of address space
      drv(0, 0, 32'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      chk("wrap_addr0", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      drv(1, 0, 32'h0, 0, 0, 64'h0);
      tick();
      drv(0, 1, 32'h0060_0213, 0, 0, 64'h0);
      tick();
      chk("wrap_idpc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_addr1", imem_req_addr, 64'h0);

      // reset asserted mid-WAIT
      drv(1, 0, 32'h0, 0, 0, 64'h0);
      tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mrst_req_valid", {63'b0, imem_req_valid}, 64'h0);
      chk("mrst_id_valid", {63'b0, id_valid}, 64'h0);
      chk("mrst_id_instr", {32'b0, id_instr}, {32'b0, NOPW});
      chk("mrst_id_pc", id_pc, 64'h0);
      drv(0, 1, 32'h0070_0293, 0, 0, 64'h0);
      @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("mrst_first_req", {63'b0, imem_req_valid}, 64'h1);
      chk("mrst_first_addr", imem_req_addr, 64'h0);
      chk("mrst_late_ign", {63'b0, id_valid}, 64'h0);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         logic [63:0] rp;
         if ($urandom_range(0, 3) == 0)
            rp = 64'hFFFF_FFFF_FFFF_FFF0 |
                 64'($urandom_range(0, 15));
         else
            rp = {$urandom, $urandom};
         drv($urandom_range(0, 1) == 1,
             $urandom_range(0, 9) < 4,
             $urandom,
             $urandom_range(0, 9) < 3,
             $urandom_range(0, 24) == 0,
             rp);
         tick();
         if (id_valid) delivered++;
      end
      chk("progress", {63'b0, delivered > 0}, 64'h1);

      drv(0, 0, 32'h0, 0, 0, 64'h0);
      tick();
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks",
               errs, checks);
      $finish;
   end

endmodule
